mb_rle_sched: RTL and testbench

MB_RLE_SCHED -- requirements
Module: mb_rle_sched

---
 rtl/mb_rle_sched_pkg.sv | 32 +++
 rtl/mb_rle_sched_if.sv | 44 ++++
 rtl/mb_rle_sched_dc_pred.sv | 53 +++++
 rtl/mb_rle_sched.sv | 94 +++++++++
 tb/tb_mb_rle_sched.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mb_rle_sched_pkg.sv
// Shared definitions for the macroblock RLE scheduler:
// FSM states, colour component codes and the block-to-component map.
package mb_rle_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    // 4:2:0 macroblock: four luma blocks, then Cb, then Cr
    localparam int         NBLK_DEF = 6;
    localparam logic [2:0] BLK_CB   = 3'd4;
    localparam logic [2:0] BLK_CR   = 3'd5;

    function automatic comp_t blk2comp(input logic [2:0] blk);
        comp_t c;
        c = COMP_Y;
        if (blk == BLK_CB) c = COMP_CB;
        if (blk == BLK_CR) c = COMP_CR;
        return c;
    endfunction

endpackage

// File: rtl/mb_rle_sched_if.sv
// Bundle of the control, RLE-encoder and Huffman-encoder signals
// seen by the scheduler (slave) and by whatever drives it (master).
interface mb_rle_sched_if #(
    parameter int W = 16
);
    logic         start;
    logic         slice_start;
    logic         busy;
    logic         done;
    logic         rle_en;
    logic         rle_rdy;
    logic [5:0]   rle_addr;
    logic [8:0]   ram_addr;
    logic         rle_h_rdy;
    logic         rle_h_en;
    logic         rle_h_end;
    logic         rle_h_dc;
    logic [W-1:0] rle_h_val;
    logic [5:0]   rle_h_len;
    logic         hf_rdy;
    logic         hf_en;
    logic         hf_end;
    logic         hf_dc;
    logic [W-1:0] hf_val;
    logic [5:0]   hf_len;
    logic [1:0]   hf_comp;

    modport slave (
        input  start, slice_start, rle_rdy, rle_addr,
        input  rle_h_en, rle_h_end, rle_h_dc,
        input  rle_h_val, rle_h_len, hf_rdy,
        output busy, done, rle_en, ram_addr, rle_h_rdy,
        output hf_en, hf_end, hf_dc, hf_val, hf_len, hf_comp
    );

    modport master (
        output start, slice_start, rle_rdy, rle_addr,
        output rle_h_en, rle_h_end, rle_h_dc,
        output rle_h_val, rle_h_len, hf_rdy,
        input  busy, done, rle_en, ram_addr, rle_h_rdy,
        input  hf_en, hf_end, hf_dc, hf_val, hf_len, hf_comp
    );

endinterface

// File: rtl/mb_rle_sched_dc_pred.sv
// DC predictors, one per colour component, and the
// difference of an incoming DC value against the selected one.
module mb_rle_sched_dc_pred
    import mb_rle_sched_pkg::*;
#(
    parameter int           W        = 16,
    parameter logic [W-1:0] DC_RESET = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  comp_t        i_comp,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_diff
);
    logic [W-1:0] r_pred_y;
    logic [W-1:0] r_pred_cb;
    logic [W-1:0] r_pred_cr;
    logic [W-1:0] w_sel;

    // Predictor of the current component
    always_comb begin
        w_sel = r_pred_y;
        unique case (i_comp)
            COMP_CB: w_sel = r_pred_cb;
            COMP_CR: w_sel = r_pred_cr;
            default: w_sel = r_pred_y;
        endcase
    end

    assign o_diff = i_val - w_sel;

    // Slice start reloads all three; a DC token replaces one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_y  <= DC_RESET;
            r_pred_cb <= DC_RESET;
            r_pred_cr <= DC_RESET;
        end else if (i_clear) begin
            r_pred_y  <= DC_RESET;
            r_pred_cb <= DC_RESET;
            r_pred_cr <= DC_RESET;
        end else if (i_load) begin
            unique case (i_comp)
                COMP_CB: r_pred_cb <= i_val;
                COMP_CR: r_pred_cr <= i_val;
                default: r_pred_y  <= i_val;
            endcase
        end
    end

endmodule

// File: rtl/mb_rle_sched.sv
// Macroblock scheduler: launches the RLE encoder once per block and
// forwards its tokens to the Huffman encoder with DC prediction.
module mb_rle_sched
    import mb_rle_sched_pkg::*;
#(
    parameter int           W        = 16,
    parameter int           NBLK     = NBLK_DEF,
    parameter logic [W-1:0] DC_RESET = '0
) (
    input logic           clk,
    input logic           reset,
    mb_rle_sched_if.slave bus
);
    localparam logic [2:0] LAST_BLK = 3'(NBLK - 1);

    state_t       r_state;
    logic [2:0]   r_blk;
    comp_t        w_comp;
    logic         w_run;
    logic         w_tok;
    logic         w_clear;
    logic         w_load;
    logic [W-1:0] w_diff;

    assign w_comp  = blk2comp(r_blk);
    assign w_run   = (r_state == S_RUN);
    assign w_tok   = w_run & bus.rle_h_en;
    assign w_clear = (r_state == S_IDLE) & bus.start
                   & bus.slice_start;
    assign w_load  = w_tok & bus.rle_h_dc;

    mb_rle_sched_dc_pred #(
        .W        (W),
        .DC_RESET (DC_RESET)
    ) u_dc_pred (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_comp  (w_comp),
        .i_val   (bus.rle_h_val),
        .o_diff  (w_diff)
    );

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_FINISH);
    assign bus.rle_en    = (r_state == S_LAUNCH) & bus.rle_rdy;
    assign bus.ram_addr  = {r_blk, bus.rle_addr};
    assign bus.rle_h_rdy = w_run & bus.hf_rdy;
    assign bus.hf_en     = w_tok & ~reset;
    assign bus.hf_end    = bus.rle_h_end;
    assign bus.hf_dc     = bus.rle_h_dc;
    assign bus.hf_len    = bus.rle_h_len;
    assign bus.hf_comp   = w_comp;
    assign bus.hf_val    = bus.rle_h_dc ? w_diff
                                        : bus.rle_h_val;

    // Block sequencing: launch, stream tokens, wait for idle, repeat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_blk   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LAUNCH;
                        r_blk   <= '0;
                    end
                end
                S_LAUNCH: begin
                    if (bus.rle_rdy) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (bus.rle_h_en && bus.rle_h_end)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (bus.rle_rdy) begin
                        if (r_blk == LAST_BLK) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_blk   <= r_blk + 3'd1;
                            r_state <= S_LAUNCH;
                        end
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mb_rle_sched.sv
// Directed-plus-random bench for mb_rle_sched with a
// component-level DC predictor model.
module tb_mb_rle_sched;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mb_rle_sched_if #(.W(W)) bus ();

    mb_rle_sched #(
        .W        (W),
        .NBLK     (6),
        .DC_RESET (16'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_en = 0;
    int n_done = 0;
    int n_hf = 0;
    int n_tok = 0;
    logic [W-1:0] pred [3];

    always @(negedge clk) begin
        if (bus.rle_en === 1'b1) n_en++;
        if (bus.done === 1'b1) n_done++;
        if (bus.hf_en === 1'b1) n_hf++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int comp_of(input int b);
        if (b < 4) return 0;
        if (b == 4) return 1;
        return 2;
    endfunction

    task automatic clr_pred();
        for (int i = 0; i < 3; i++) pred[i] = '0;
    endtask

    task automatic drive(input bit en, input bit dc, input bit e,
                         input logic [W-1:0] v);
        bus.rle_h_en  = en;
        bus.rle_h_dc  = dc;
        bus.rle_h_end = e;
        bus.rle_h_val = v;
        bus.rle_h_len = 6'($urandom);
    endtask

    // mode: 0 plain, 1 hf_rdy low 10 cycles, 2 start while busy,
    // 3 reset right after the DC token is presented
    task automatic run_block(input int b, input logic [W-1:0] dcv,
                             input int nac, input int mode);
        bit found;
        int c;
        logic [W-1:0] v;
        logic [W-1:0] e;
        found = 0;
        c = comp_of(b);
        #1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.rle_en === 1'b1) found = 1;
            else tick();
        end
        chk("launch", 32'(found), 1);
        chk("ram_blk", 32'(bus.ram_addr[8:6]), b);
        bus.rle_addr = 6'($urandom);
        #1;
        chk("ram_lo", 32'(bus.ram_addr[5:0]), 32'(bus.rle_addr));
        tick();
        bus.rle_rdy = 1'b0;
        #1;
        chk("run_rle_en", 32'(bus.rle_en), 0);
        if (mode == 1) begin
            bus.hf_rdy = 1'b0;
            for (int i = 0; i < 10; i++) begin
                #1;
                chk("hold_h_rdy", 32'(bus.rle_h_rdy), 0);
                chk("hold_hf_en", 32'(bus.hf_en), 0);
                tick();
            end
            bus.hf_rdy = 1'b1;
        end
        if (mode == 2) begin
            bus.start = 1'b1;
            bus.slice_start = 1'b1;
            tick();
            bus.start = 1'b0;
            bus.slice_start = 1'b0;
            #1;
            chk("busy_start_busy", 32'(bus.busy), 1);
            chk("busy_start_blk", 32'(bus.ram_addr[8:6]), b);
        end
        drive(1, 1, nac == 0, dcv);
        #1;
        e = dcv - pred[c];
        chk("h_rdy", 32'(bus.rle_h_rdy), 1);
        chk("dc_en", 32'(bus.hf_en), 1);
        chk("dc_flag", 32'(bus.hf_dc), 1);
        chk("dc_val", 32'(bus.hf_val), 32'(e));
        chk("dc_comp", 32'(bus.hf_comp), c);
        chk("dc_len", 32'(bus.hf_len), 32'(bus.rle_h_len));
        if (mode == 3) begin
            reset = 1'b1;
            #1;
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_h_rdy", 32'(bus.rle_h_rdy), 0);
            chk("rst_hf_en", 32'(bus.hf_en), 0);
            chk("rst_rle_en", 32'(bus.rle_en), 0);
            chk("rst_done", 32'(bus.done), 0);
            tick();
            reset = 1'b0;
            drive(0, 0, 0, '0);
            bus.rle_rdy = 1'b1;
            clr_pred();
            return;
        end
        n_tok++;
        tick();
        pred[c] = dcv;
        for (int k = 0; k < nac; k++) begin
            v = W'($urandom);
            drive(1, 0, k == nac - 1, v);
            #1;
            chk("ac_val", 32'(bus.hf_val), 32'(v));
            chk("ac_end", 32'(bus.hf_end), 32'(k == nac - 1));
            chk("ac_comp", 32'(bus.hf_comp), c);
            n_tok++;
            tick();
        end
        drive(1, 1, 0, W'($urandom));
        #1;
        chk("drain_h_rdy", 32'(bus.rle_h_rdy), 0);
        chk("drain_hf_en", 32'(bus.hf_en), 0);
        tick();
        drive(0, 0, 0, '0);
        tick();
        bus.rle_rdy = 1'b1;
    endtask

    task automatic run_mb(input bit slice, input int hold_blk,
                          input int pstart_blk, input int abort_blk,
                          input bit hold_launch,
                          input logic [W-1:0] dc0,
                          input logic [W-1:0] dc1,
                          input logic [W-1:0] dc4);
        int en0;
        int dn0;
        int hf0;
        int tk0;
        int mode;
        logic [W-1:0] v;
        en0 = n_en;
        dn0 = n_done;
        hf0 = n_hf;
        tk0 = n_tok;
        tick();
        if (hold_launch) bus.rle_rdy = 1'b0;
        bus.start = 1'b1;
        bus.slice_start = slice;
        #1;
        chk("idle_busy", 32'(bus.busy), 0);
        tick();
        bus.start = 1'b0;
        bus.slice_start = 1'b0;
        if (slice) clr_pred();
        if (hold_launch) begin
            for (int i = 0; i < 3; i++) begin
                chk("launch_wait_en", 32'(bus.rle_en), 0);
                chk("launch_wait_busy", 32'(bus.busy), 1);
                tick();
            end
            bus.rle_rdy = 1'b1;
        end
        for (int b = 0; b < 6; b++) begin
            if (b == 0) v = dc0;
            else if (b == 1) v = dc1;
            else if (b == 4) v = dc4;
            else v = W'($urandom);
            mode = 0;
            if (b == hold_blk) mode = 1;
            if (b == pstart_blk) mode = 2;
            if (b == abort_blk) mode = 3;
            run_block(b, v, int'($urandom_range(0, 3)), mode);
            if (b == abort_blk) begin
                chk("abort_en_cnt", n_en - en0, b + 1);
                chk("abort_hf_cnt", n_hf - hf0, n_tok - tk0);
                return;
            end
        end
        tick();
        chk("fin_done", 32'(bus.done), 1);
        chk("fin_busy", 32'(bus.busy), 1);
        tick();
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_busy_end", 32'(bus.busy), 0);
        chk("en_pulses", n_en - en0, 6);
        chk("done_pulses", n_done - dn0, 1);
        chk("hf_tokens", n_hf - hf0, n_tok - tk0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.slice_start = 1'b0;
        bus.rle_rdy = 1'b1;
        bus.rle_addr = '0;
        bus.hf_rdy = 1'b1;
        drive(1, 1, 0, 16'h1234);
        clr_pred();
        tick();
        tick();
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_rle_en", 32'(bus.rle_en), 0);
        chk("reset_h_rdy", 32'(bus.rle_h_rdy), 0);
        chk("reset_hf_en", 32'(bus.hf_en), 0);
        chk("reset_ram_blk", 32'(bus.ram_addr[8:6]), 0);
        drive(0, 0, 0, '0);
        reset = 1'b0;

        run_mb(1, 2, -1, -1, 1, 16'hFFFF, 16'd5, 16'd3);

        drive(1, 1, 1, W'($urandom));
        #1;
        chk("idle_token_hf_en", 32'(bus.hf_en), 0);
        tick();
        drive(0, 0, 0, '0);

        run_mb(0, -1, 3, -1, 0, 16'hFFFF,
               W'($urandom), W'($urandom));

        run_mb(0, -1, -1, 3, 0, W'($urandom),
               W'($urandom), W'($urandom));
        run_mb(0, -1, -1, -1, 0, W'($urandom),
               W'($urandom), W'($urandom));

        for (int m = 0; m < 3; m++) begin
            run_mb(1'($urandom), -1, -1, -1, 1'($urandom),
                   W'($urandom), W'($urandom), W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
